// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions
// State indices, op codes and datapath widths.
package seq_alu_pkg;

    localparam int W  = 8;
    localparam int RW = 9;
    localparam int NS = 17;

    localparam logic [4:0] S_IDLE      = 5'd0;
    localparam logic [4:0] S_LOAD_M    = 5'd1;
    localparam logic [4:0] S_DISPATCH  = 5'd2;
    localparam logic [4:0] S_ADD       = 5'd3;
    localparam logic [4:0] S_SUB       = 5'd4;
    localparam logic [4:0] S_BOOTH_CHK = 5'd5;
    localparam logic [4:0] S_BOOTH_ADD = 5'd6;
    localparam logic [4:0] S_BOOTH_SUB = 5'd7;
    localparam logic [4:0] S_BOOTH_SHR = 5'd8;
    localparam logic [4:0] S_DIV_SHL   = 5'd9;
    localparam logic [4:0] S_DIV_ADD   = 5'd10;
    localparam logic [4:0] S_DIV_SUB   = 5'd11;
    localparam logic [4:0] S_DIV_QSET  = 5'd12;
    localparam logic [4:0] S_DIV_FIX   = 5'd13;
    localparam logic [4:0] S_OUT_HI    = 5'd14;
    localparam logic [4:0] S_OUT_LO    = 5'd15;
    localparam logic [4:0] S_DONE      = 5'd16;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    function automatic logic [NS-1:0] onehot(
        input logic [4:0] idx
    );
        return {{(NS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu byte bus
// Start strobe, op code, operand and result lines.
interface seq_alu_if;
    import seq_alu_pkg::*;

    logic         BEGIN;
    logic [1:0]   op_code;
    logic [W-1:0] inbus;
    logic [W-1:0] outbus;
    logic         END;

    modport master (
        output BEGIN, op_code, inbus,
        input  outbus, END
    );

    modport slave (
        input  BEGIN, op_code, inbus,
        output outbus, END
    );

endinterface

// File: rtl/seq_alu_addsub9.sv
// seq_alu 9-bit ripple adder/subtractor
// y = a + b, or a - b when i_sub (two's complement, carry-in = sub).
module addsub9 (
    input  logic [8:0] i_a,
    input  logic [8:0] i_b,
    input  logic       i_sub,
    output logic [8:0] o_y
);

    logic [8:0] w_b;

    assign w_b = i_b ^ {9{i_sub}};

    // Bit-serial carry chain, LSB first.
    always_comb begin
        logic w_c;
        w_c = i_sub;
        o_y = '0;
        for (int i = 0; i < 9; i++) begin
            o_y[i] = i_a[i] ^ w_b[i] ^ w_c;
            w_c = (i_a[i] & w_b[i])
                | (w_c & (i_a[i] ^ w_b[i]));
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu multi-cycle ALU
// Add, sub, Booth multiply and non-restoring divide on A/Q/M.
module seq_alu
    import seq_alu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    seq_alu_if.slave      bus,
    output logic [NS-1:0] act_state_debug,
    output logic [NS-1:0] next_state_debug,
    output logic [RW-1:0] A_reg_debug,
    output logic [RW-1:0] Q_reg_debug,
    output logic [RW-1:0] M_reg_debug
);

    logic [NS-1:0] r_state;
    logic [NS-1:0] w_next;
    logic [4:0]    w_nidx;
    logic [RW-1:0] r_A;
    logic [RW-1:0] r_Q;
    logic [RW-1:0] r_M;
    logic [RW-1:0] w_sum;
    logic [2:0]    r_cnt;
    logic [1:0]    r_op;
    logic [W-1:0]  r_out;
    logic          w_sub;

    assign w_sub = r_state[S_SUB]
                 | r_state[S_BOOTH_SUB]
                 | r_state[S_DIV_SUB];

    addsub9 u_addsub (
        .i_a   (r_A),
        .i_b   (r_M),
        .i_sub (w_sub),
        .o_y   (w_sum)
    );

    // Next-state selection from the one-hot current state.
    always_comb begin
        w_nidx = S_IDLE;
        unique case (1'b1)
            r_state[S_IDLE]: begin
                if (bus.BEGIN) w_nidx = S_LOAD_M;
            end
            r_state[S_LOAD_M]: w_nidx = S_DISPATCH;
            r_state[S_DISPATCH]: begin
                case (r_op)
                    OP_ADD:  w_nidx = S_ADD;
                    OP_SUB:  w_nidx = S_SUB;
                    OP_MUL:  w_nidx = S_BOOTH_CHK;
                    default: w_nidx = S_DIV_SHL;
                endcase
            end
            r_state[S_ADD],
            r_state[S_SUB]: w_nidx = S_OUT_HI;
            r_state[S_BOOTH_CHK]: begin
                case (r_Q[1:0])
                    2'b10:   w_nidx = S_BOOTH_SUB;
                    2'b01:   w_nidx = S_BOOTH_ADD;
                    default: w_nidx = S_BOOTH_SHR;
                endcase
            end
            r_state[S_BOOTH_ADD],
            r_state[S_BOOTH_SUB]: w_nidx = S_BOOTH_SHR;
            r_state[S_BOOTH_SHR]: begin
                w_nidx = (r_cnt == 3'd7) ? S_OUT_HI
                                         : S_BOOTH_CHK;
            end
            r_state[S_DIV_SHL]: begin
                w_nidx = r_A[RW-1] ? S_DIV_ADD
                                   : S_DIV_SUB;
            end
            r_state[S_DIV_ADD],
            r_state[S_DIV_SUB]: w_nidx = S_DIV_QSET;
            r_state[S_DIV_QSET]: begin
                w_nidx = (r_cnt == 3'd7) ? S_DIV_FIX
                                         : S_DIV_SHL;
            end
            r_state[S_DIV_FIX]: w_nidx = S_OUT_HI;
            r_state[S_OUT_HI]: begin
                w_nidx = r_op[1] ? S_OUT_LO : S_DONE;
            end
            r_state[S_OUT_LO]: w_nidx = S_DONE;
            r_state[S_DONE]:   w_nidx = S_IDLE;
            default:           w_nidx = S_IDLE;
        endcase
    end

    assign w_next = onehot(w_nidx);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= onehot(S_IDLE);
        else       r_state <= w_next;
    end

    // Operand capture, arithmetic steps and result output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_A   <= '0;
            r_Q   <= '0;
            r_M   <= '0;
            r_cnt <= '0;
            r_op  <= '0;
            r_out <= '0;
        end else begin
            unique case (1'b1)
                r_state[S_IDLE]: begin
                    if (bus.BEGIN) begin
                        r_op <= bus.op_code;
                        case (bus.op_code)
                            OP_MUL: begin
                                r_A <= '0;
                                r_Q <= {bus.inbus, 1'b0};
                            end
                            OP_DIV: begin
                                r_A <= '0;
                                r_Q <= {1'b0, bus.inbus};
                            end
                            default: begin
                                r_A <= {bus.inbus[W-1],
                                        bus.inbus};
                            end
                        endcase
                    end
                end
                r_state[S_LOAD_M]: begin
                    r_M <= (r_op == OP_DIV)
                         ? {1'b0, bus.inbus}
                         : {bus.inbus[W-1], bus.inbus};
                end
                r_state[S_DISPATCH]: r_cnt <= '0;
                r_state[S_ADD],
                r_state[S_SUB],
                r_state[S_BOOTH_ADD],
                r_state[S_BOOTH_SUB],
                r_state[S_DIV_ADD],
                r_state[S_DIV_SUB]: r_A <= w_sum;
                r_state[S_BOOTH_SHR]: begin
                    r_A   <= {r_A[RW-1], r_A[RW-1:1]};
                    r_Q   <= {r_A[0], r_Q[RW-1:1]};
                    r_cnt <= r_cnt + 3'd1;
                end
                r_state[S_DIV_SHL]: begin
                    r_A      <= {r_A[W-1:0], r_Q[W-1]};
                    r_Q[W-1:0] <= {r_Q[W-2:0], 1'b0};
                end
                r_state[S_DIV_QSET]: begin
                    r_Q[0] <= ~r_A[RW-1];
                    r_cnt  <= r_cnt + 3'd1;
                end
                r_state[S_DIV_FIX]: begin
                    if (r_A[RW-1]) r_A <= w_sum;
                end
                r_state[S_OUT_HI]: r_out <= r_A[W-1:0];
                r_state[S_OUT_LO]: begin
                    r_out <= (r_op == OP_MUL) ? r_Q[RW-1:1]
                                              : r_Q[W-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.outbus       = r_out;
    assign bus.END          = r_state[S_DONE];
    assign act_state_debug  = r_state;
    assign next_state_debug = w_next;
    assign A_reg_debug      = r_A;
    assign Q_reg_debug      = r_Q;
    assign M_reg_debug      = r_M;

endmodule

// File: tb/tb_seq_alu.sv
// seq_alu testbench
// Vector table, random ops vs arithmetic model, reset/BEGIN corners.
module tb_seq_alu;
    import seq_alu_pkg::*;

    typedef struct {
        logic [1:0] op;
        logic [7:0] x;
        logic [7:0] m;
        logic [7:0] hi;
        logic [7:0] lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [16:0] act_dbg;
    logic [16:0] nxt_dbg;
    logic [8:0]  a_dbg;
    logic [8:0]  q_dbg;
    logic [8:0]  m_dbg;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    seq_alu_if bus ();

    seq_alu dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .act_state_debug  (act_dbg),
        .next_state_debug (nxt_dbg),
        .A_reg_debug      (a_dbg),
        .Q_reg_debug      (q_dbg),
        .M_reg_debug      (m_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    // Arithmetic meaning of each op plus cycle cost.
    function automatic void model(
        input  logic [1:0] op,
        input  logic [7:0] x,
        input  logic [7:0] m,
        output logic [7:0] hi,
        output logic [7:0] lo,
        output int         edges
    );
        logic signed [15:0] p;
        logic prv;
        hi = 8'h00;
        lo = 8'h00;
        edges = 5;
        case (op)
            2'b00: begin lo = x + m; hi = lo; end
            2'b01: begin lo = x - m; hi = lo; end
            2'b10: begin
                p = $signed(x) * $signed(m);
                hi = p[15:8];
                lo = p[7:0];
                prv = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    edges += (x[i] != prv) ? 3 : 2;
                    prv = x[i];
                end
            end
            default: begin
                if (m == 8'd0) begin
                    hi = x;
                    lo = 8'hFF;
                end else begin
                    hi = x % m;
                    lo = x / m;
                end
                edges = 30;
            end
        endcase
    endfunction

    // Call at a negedge with the DUT in IDLE.
    task automatic run_op(input logic [1:0] op,
                          input logic [7:0] x,
                          input logic [7:0] m,
                          input logic [7:0] ehi,
                          input logic [7:0] elo,
                          input bit hold,
                          input string nm);
        logic [7:0] dh, dl, prev;
        int eedges, n;
        bit got;
        model(op, x, m, dh, dl, eedges);
        bus.BEGIN = 1'b1;
        bus.op_code = op;
        bus.inbus = x;
        @(negedge clk);
        n = 1;
        if (!hold) bus.BEGIN = 1'b0;
        bus.inbus = m;
        got = 1'b0;
        prev = bus.outbus;
        while (!got && n < 100) begin
            prev = bus.outbus;
            @(negedge clk);
            n++;
            got = bus.END;
        end
        chk({nm, " end"}, 32'(got), 32'd1);
        chk({nm, " latency"}, 32'(n), 32'(eedges));
        chk({nm, " result"}, 32'(bus.outbus), 32'(elo));
        if (op[1])
            chk({nm, " hi"}, 32'(prev), 32'(ehi));
        @(negedge clk);
        chk({nm, " idle"}, 32'({bus.END, act_dbg}),
            32'h1);
        bus.BEGIN = 1'b0;
    endtask

    // Every cycle: one-hot state and END only in DONE.
    always @(negedge clk) begin
        if (mon_en) begin
            n_chk++;
            if (!$onehot(act_dbg) || !$onehot(nxt_dbg)
                || (bus.END !== act_dbg[S_DONE])) begin
                n_fail++;
                $display("FAIL onehot: act %h next %h end %b",
                         act_dbg, nxt_dbg, bus.END);
            end
        end
    end

    initial begin
        vec_t tv[13];
        logic [1:0] op;
        logic [7:0] x, m, eh, el;
        int ed, n;

        tv[0]  = '{2'b00, 8'd56,  8'd89,  8'h91, 8'h91};
        tv[1]  = '{2'b01, 8'd56,  8'd89,  8'hDF, 8'hDF};
        tv[2]  = '{2'b10, 8'd56,  8'd89,  8'h13, 8'h78};
        tv[3]  = '{2'b10, 8'hFD,  8'd5,   8'hFF, 8'hF1};
        tv[4]  = '{2'b11, 8'd123, 8'd89,  8'h22, 8'h01};
        tv[5]  = '{2'b11, 8'd200, 8'd0,   8'hC8, 8'hFF};
        tv[6]  = '{2'b00, 8'hFF,  8'h01,  8'h00, 8'h00};
        tv[7]  = '{2'b01, 8'h00,  8'h01,  8'hFF, 8'hFF};
        tv[8]  = '{2'b10, 8'h80,  8'h80,  8'h40, 8'h00};
        tv[9]  = '{2'b10, 8'h7F,  8'h80,  8'hC0, 8'h80};
        tv[10] = '{2'b11, 8'hFF,  8'h01,  8'h00, 8'hFF};
        tv[11] = '{2'b11, 8'h05,  8'hFF,  8'h05, 8'h00};
        tv[12] = '{2'b11, 8'hFF,  8'hFF,  8'h00, 8'h01};

        bus.BEGIN = 1'b0;
        bus.op_code = 2'b00;
        bus.inbus = 8'h00;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst state", 32'(act_dbg), 32'h1);
        chk("rst A", 32'(a_dbg), 32'h0);
        chk("rst Q", 32'(q_dbg), 32'h0);
        chk("rst M", 32'(m_dbg), 32'h0);
        chk("rst out", 32'(bus.outbus), 32'h0);
        chk("rst end", 32'(bus.END), 32'h0);
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++)
            run_op(tv[i].op, tv[i].x, tv[i].m,
                   tv[i].hi, tv[i].lo, 1'b0,
                   $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            x = 8'($urandom);
            m = 8'($urandom);
            if ($urandom_range(0, 7) == 0) m = 8'h00;
            model(op, x, m, eh, el, ed);
            run_op(op, x, m, eh, el, 1'b0,
                   $sformatf("rnd%0d", i));
        end

        model(2'b10, 8'hC5, 8'h3B, eh, el, ed);
        run_op(2'b10, 8'hC5, 8'h3B, eh, el, 1'b1,
               "held begin mul");
        model(2'b11, 8'hE7, 8'h0D, eh, el, ed);
        run_op(2'b11, 8'hE7, 8'h0D, eh, el, 1'b1,
               "held begin div");

        bus.BEGIN = 1'b1;
        bus.op_code = 2'b10;
        bus.inbus = 8'd56;
        @(negedge clk);
        bus.BEGIN = 1'b0;
        bus.inbus = 8'd89;
        n = 0;
        while (!act_dbg[S_BOOTH_SHR] && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("reach booth_shr",
            32'(act_dbg[S_BOOTH_SHR]), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort state", 32'(act_dbg), 32'h1);
        chk("abort A", 32'(a_dbg), 32'h0);
        chk("abort Q", 32'(q_dbg), 32'h0);
        chk("abort M", 32'(m_dbg), 32'h0);
        chk("abort out", 32'(bus.outbus), 32'h0);
        chk("abort end", 32'(bus.END), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post abort idle",
                32'({bus.END, act_dbg}), 32'h1);
        end
        run_op(2'b00, 8'd1, 8'd1, 8'd2, 8'd2, 1'b0,
               "post reset add");

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
